pwm4_gen: RTL and testbench
===========================

PWM4_GEN -- requirements
Module: pwm4_gen

Interface
REQ-001 The block SHALL have these ports:
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high reset
- count  input  4  free-running count from the upstream 4-bit counter (0..15, +1 per clk)
- duty  input  5  requested high-time in counts, 0..16
- duty_valid  input  1  duty offered this cycle
- duty_ready  output  1  block can accept a duty value this cycle
- err_clr  input  1  clears seq_err
- pwm  output  1  registered PWM output
- period_done  output  1  one-cycle pulse per completed 16-count period
- period_cnt  output  8  number of completed periods, wraps
- seq_err  output  1  sticky flag: count stream was not contiguous

REQ-002 All state SHALL be clocked by clk only, with no other clock or asynchronous input.

Function
REQ-003 The block SHALL hold an active duty register (duty_act, 5 bits) and a one-entry pending register (pend, with a pend_full flag).

REQ-004 duty_ready SHALL equal !pend_full.

REQ-005 A transfer SHALL occur when duty_valid && duty_ready; duty is captured into pend and pend_full is set.

REQ-006 A captured duty value greater than 16 SHALL be clamped to 16 before it is stored.

REQ-007 The period boundary is a cycle where count == 4'hF; at a boundary with pend_full set, duty_act <= pend and pend_full is cleared.

REQ-008 A transfer that occurs in a boundary cycle while pend is empty SHALL land in pend, and SHALL be applied at the next boundary rather than the current one.

REQ-009 In every cycle, pwm <= (count < duty_act), with a latency of 1 clk from count.

REQ-010 duty_act = 0 SHALL make pwm constantly 0, and duty_act = 16 SHALL make pwm constantly 1.

REQ-011 A new duty SHALL first affect pwm in the cycle after count == 0 is sampled, so a period is never split between two duty values.

REQ-012 period_done SHALL be 1 for exactly one cycle, in the cycle after a boundary is sampled.

REQ-013 period_cnt SHALL increment by 1 in that same cycle, and SHALL wrap from 255 to 0.

REQ-014 Continuity check: after the first sample following reset, if count != (prev_count + 1) mod 16, seq_err SHALL be set in the next cycle.

REQ-015 The first sampled count after reset SHALL NOT be checked.

REQ-016 The 15 -> 0 wrap SHALL be treated as contiguous.

REQ-017 err_clr SHALL clear seq_err; if err_clr and a new discontinuity occur in the same cycle, seq_err SHALL remain 1.

REQ-018 Duty handling and period counting SHALL continue unchanged while seq_err is set.

Reset
REQ-019 While reset is sampled high, the block SHALL drive pwm=0, period_done=0, period_cnt=0 and seq_err=0, clear duty_act to 0 and pend_full to 0, and invalidate prev_count.

REQ-020 duty_ready SHALL read 1 in the first cycle after reset is released.

REQ-021 A reset asserted mid-period SHALL discard any pending duty.

REQ-022 The first boundary after reset release SHALL produce a normal period_done pulse.

REQ-023 reset SHALL take priority over every other input in the same cycle.

Structure
REQ-024 A shared package pwm4_pkg SHALL hold these constants: CNT_W=4, DUTY_W=5, DUTY_MAX=16, CNT_LAST=4'hF, PCNT_W=8.

REQ-025 The continuity checker SHALL be a sub-module pwm4_seq_check with ports clk, reset, count, err_clr and seq_err; it holds prev_count and its valid bit.

REQ-026 The remaining logic (handshake, shadow register, compare, period counter) SHALL live in pwm4_gen, with a total implementation of 120-400 lines.

Verification
REQ-027 The bench SHALL cover the following directed scenarios:
- Basic duty: reset, offer duty=4 while count=3 -> pwm high for counts 0..3 of the next period (seen 1 clk later), low for 4..15; period_done pulses once per 16 clk.
- Extremes: duty=0 then duty=16, then duty=25 -> pwm constant 0 for a whole period; then constant 1; duty=25 is clamped and behaves as 16.
- Handshake backpressure: two duty offers before a boundary -> first accepted, duty_ready=0 until the boundary, second accepted the cycle after, applied one period later.
- Boundary collision: pend empty, offer duty=8 exactly when count=15 -> current period keeps the old duty; duty=8 takes effect after the following 15.
- Continuity: drive count sequence 5,6,9 -> seq_err=1 one cycle after 9 is sampled; 15->0 sets no error; err_clr together with a new skip -> seq_err stays 1.
- Reset mid-operation: pending duty=12 and period_cnt=3, then assert reset at count=7 -> all outputs 0, pending lost, duty_ready=1 after release; 256 periods later period_cnt wraps to 0.

Source files
------------

// File: rtl/pwm4_pkg.sv
// Shared constants and helpers for the 4-bit-count PWM generator.
package pwm4_pkg;

    localparam int             CNT_W    = 4;
    localparam int             DUTY_W   = 5;
    localparam int             DUTY_MAX = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = 4'hF;
    localparam int             PCNT_W   = 8;

    // Requests above a full period would otherwise read as "always high" only by accident.
    function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] d);
        return (d > DUTY_W'(DUTY_MAX)) ? DUTY_W'(DUTY_MAX) : d;
    endfunction

endpackage

// File: rtl/pwm4_seq_check.sv
// Sticky detector for gaps in the upstream count stream (15 -> 0 is a normal wrap).
module pwm4_seq_check
    import pwm4_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] count,
    input  logic             err_clr,
    output logic             seq_err
);

    logic [CNT_W-1:0] prev_count;
    logic             prev_valid;
    logic [CNT_W-1:0] next_exp;
    logic             skip;

    assign next_exp = prev_count + CNT_W'(1);
    // The first sample after reset has no predecessor, so it is never flagged.
    assign skip     = prev_valid && (count != next_exp);

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_count <= '0;
            prev_valid <= 1'b0;
            seq_err    <= 1'b0;
        end else begin
            prev_count <= count;
            prev_valid <= 1'b1;
            if (skip) begin
                seq_err <= 1'b1;
            end else if (err_clr) begin
                seq_err <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pwm4_gen.sv
// PWM generator slaved to an external 4-bit counter, with a one-entry duty
// shadow register that only takes effect on period boundaries.
module pwm4_gen
    import pwm4_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [CNT_W-1:0]  count,
    input  logic [DUTY_W-1:0] duty,
    input  logic              duty_valid,
    output logic              duty_ready,
    input  logic              err_clr,
    output logic              pwm,
    output logic              period_done,
    output logic [PCNT_W-1:0] period_cnt,
    output logic              seq_err
);

    logic [DUTY_W-1:0] duty_act;
    logic [DUTY_W-1:0] pend;
    logic              pend_full;
    logic              boundary;
    logic              xfer;

    // duty moves when duty_valid && duty_ready at a rising edge; duty_ready
    // depends only on the pending slot, never on duty_valid.
    assign duty_ready = !pend_full;
    assign xfer       = duty_valid && duty_ready;
    assign boundary   = (count == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            duty_act    <= '0;
            pend        <= '0;
            pend_full   <= 1'b0;
            pwm         <= 1'b0;
            period_done <= 1'b0;
            period_cnt  <= '0;
        end else begin
            pwm         <= ({{(DUTY_W-CNT_W){1'b0}}, count} < duty_act);
            period_done <= boundary;
            if (boundary) begin
                period_cnt <= period_cnt + PCNT_W'(1);
            end
            // A full slot blocks xfer, so promotion and capture never collide;
            // a capture in a boundary cycle therefore waits a whole period.
            if (boundary && pend_full) begin
                duty_act  <= pend;
                pend_full <= 1'b0;
            end else if (xfer) begin
                pend      <= clamp_duty(duty);
                pend_full <= 1'b1;
            end
        end
    end

    pwm4_seq_check u_seq_check (
        .clk     (clk),
        .reset   (reset),
        .count   (count),
        .err_clr (err_clr),
        .seq_err (seq_err)
    );

endmodule

// File: tb/tb_pwm4_gen.sv
// Directed bench for pwm4_gen: the bench plays the upstream counter and
// checks every output against hand-derived values.
module tb_pwm4_gen;

    logic       clk;
    logic       reset;
    logic [3:0] count;
    logic [4:0] duty;
    logic       duty_valid;
    logic       duty_ready;
    logic       err_clr;
    logic       pwm;
    logic       period_done;
    logic [7:0] period_cnt;
    logic       seq_err;

    int         vectors;
    int         miscompares;
    logic [3:0] cnt;

    pwm4_gen dut (
        .clk         (clk),
        .reset       (reset),
        .count       (count),
        .duty        (duty),
        .duty_valid  (duty_valid),
        .duty_ready  (duty_ready),
        .err_clr     (err_clr),
        .pwm         (pwm),
        .period_done (period_done),
        .period_cnt  (period_cnt),
        .seq_err     (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present cnt for one edge, then settle 1 time unit past that edge.
    task automatic tick();
        count = cnt;
        @(posedge clk);
        #1;
        cnt = cnt + 4'd1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // One full period starting at count 0; d is the duty active for it.
    task automatic run_period(input string tag, input int d, input logic [7:0] pcnt_exp,
                              input int offer_at, input logic [4:0] offer_val);
        for (int i = 0; i < 16; i++) begin
            if (i == offer_at) begin
                duty       = offer_val;
                duty_valid = 1'b1;
            end
            tick();
            duty_valid = 1'b0;
            chk({tag, "_pwm"}, pwm, (i < d));
            chk({tag, "_done"}, period_done, (i == 15));
        end
        chk({tag, "_pcnt"}, period_cnt, pcnt_exp);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        duty        = '0;
        duty_valid  = 1'b0;
        err_clr     = 1'b0;
        cnt         = 4'd0;
        count       = 4'd0;

        // Reset state
        tick();
        tick();
        chk("rst_pwm", pwm, 0);
        chk("rst_done", period_done, 0);
        chk("rst_pcnt", period_cnt, 0);
        chk("rst_seq", seq_err, 0);
        reset = 1'b0;
        cnt   = 4'd0;
        chk("rst_ready", duty_ready, 1);

        // Basic duty: offer 4 at count 3
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pre_pwm", pwm, 0);
        end
        duty       = 5'd4;
        duty_valid = 1'b1;
        tick();
        duty_valid = 1'b0;
        chk("basic_ready_lo", duty_ready, 0);
        for (int i = 4; i < 15; i++) begin
            tick();
            chk("basic_hold", duty_ready, 0);
            chk("basic_old_pwm", pwm, 0);
        end
        tick();
        chk("basic_b_done", period_done, 1);
        chk("basic_b_pcnt", period_cnt, 1);
        chk("basic_b_ready", duty_ready, 1);
        chk("basic_b_pwm", pwm, 0);
        run_period("basic", 4, 8'd2, -1, 5'd0);

        // Extremes: 0, 16, then 25 (clamped)
        run_period("ext_prev", 4, 8'd3, 0, 5'd0);
        run_period("duty0", 0, 8'd4, 0, 5'd16);
        run_period("duty16", 16, 8'd5, 0, 5'd25);
        run_period("duty25", 16, 8'd6, -1, 5'd0);

        // Backpressure: 2 accepted at count 2, 10 held until the boundary frees the slot
        for (int i = 0; i < 16; i++) begin
            if (i == 2) begin
                duty       = 5'd2;
                duty_valid = 1'b1;
            end
            if (i == 3) duty = 5'd10;
            tick();
            chk("bp_ready", duty_ready, (i < 2 || i == 15));
            chk("bp_pwm", pwm, 1);
        end
        chk("bp_pcnt", period_cnt, 7);
        run_period("bp_first", 2, 8'd8, 0, 5'd10);
        run_period("bp_second", 10, 8'd9, -1, 5'd0);

        // Boundary collision: offer 8 exactly at count 15 with the slot empty
        run_period("coll_cur", 10, 8'd10, 15, 5'd8);
        chk("coll_ready", duty_ready, 0);
        run_period("coll_old", 10, 8'd11, -1, 5'd0);
        run_period("coll_new", 8, 8'd12, -1, 5'd0);

        // Continuity checker
        chk("cont_init", seq_err, 0);
        for (int i = 0; i < 7; i++) tick();
        chk("cont_ok", seq_err, 0);
        cnt = 4'd9;
        tick();
        chk("cont_skip", seq_err, 1);
        for (int i = 10; i < 16; i++) tick();
        chk("cont_err_done", period_done, 1);
        chk("cont_err_pcnt", period_cnt, 13);
        chk("cont_sticky", seq_err, 1);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("cont_clr", seq_err, 0);
        for (int i = 2; i < 16; i++) tick();
        tick();
        chk("cont_wrap", seq_err, 0);
        chk("cont_wrap_pcnt", period_cnt, 14);
        cnt     = 4'd5;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("cont_clr_vs_skip", seq_err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("cont_clr2", seq_err, 0);
        for (int i = 7; i < 16; i++) tick();
        chk("cont_end_pcnt", period_cnt, 15);

        // Reset mid-operation
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cnt   = 4'd0;
        chk("r1_pcnt", period_cnt, 0);
        run_period("r1_p1", 0, 8'd1, 0, 5'd16);
        run_period("r1_p2", 16, 8'd2, -1, 5'd0);
        run_period("r1_p3", 16, 8'd3, -1, 5'd0);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                duty       = 5'd12;
                duty_valid = 1'b1;
            end
            tick();
            duty_valid = 1'b0;
        end
        cnt = 4'd5;
        tick();
        tick();
        chk("mid_ready", duty_ready, 0);
        chk("mid_pwm", pwm, 1);
        chk("mid_seq", seq_err, 1);
        reset      = 1'b1;
        duty       = 5'd5;
        duty_valid = 1'b1;
        err_clr    = 1'b0;
        tick();
        reset      = 1'b0;
        duty_valid = 1'b0;
        chk("mid_rst_pwm", pwm, 0);
        chk("mid_rst_done", period_done, 0);
        chk("mid_rst_pcnt", period_cnt, 0);
        chk("mid_rst_seq", seq_err, 0);
        chk("mid_rst_ready", duty_ready, 1);
        cnt = 4'd3;
        tick();
        chk("post_first_seq", seq_err, 0);
        chk("post_first_ready", duty_ready, 1);
        for (int i = 4; i < 16; i++) begin
            tick();
            chk("post_pwm", pwm, 0);
        end
        chk("post_done", period_done, 1);
        chk("post_pcnt", period_cnt, 1);
        run_period("lost", 0, 8'd2, -1, 5'd0);
        for (int p = 0; p < 253; p++) begin
            for (int i = 0; i < 16; i++) tick();
        end
        chk("pre_wrap_pcnt", period_cnt, 255);
        run_period("wrap", 0, 8'd0, -1, 5'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
